vga_face_scheduler: RTL and testbench

Frame-synchronous controller for the face streamer's `face_select` input. It accepts face-change requests from the audio/emotion classifier and tracks frame boundaries by tapping the streamer's Avalon-ST handshake. It commits a new face only at an end-of-frame handshake, so no frame is ever torn. A minimum hold time between switches prevents flicker when the classifier output chatters.

---
 rtl/vga_face_scheduler.sv | 159 +++++++++++++++
 tb/tb_vga_face_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_face_scheduler.sv
// Frame-synchronous face_select controller: queues face-change requests and commits them only at an
// accepted end-of-frame handshake, after a minimum hold. Optional idle auto-advance: VGA_FACE_AUTOCYCLE_EN.
module vga_face_scheduler #(
    parameter int         MIN_HOLD_FRAMES  = 30,
    parameter int         AUTO_IDLE_FRAMES = 600,
    parameter logic [1:0] DEFAULT_FACE     = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_face,
    input  logic        st_valid,
    input  logic        st_ready,
    input  logic        st_endofpacket,
    output logic [1:0]  face_select,
    output logic        switch_pulse,
    output logic        pending,
    output logic        req_error,
    output logic [15:0] frame_count
);

    localparam int HOLD_W = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD_FRAMES - 1);

    typedef enum logic {
        S_HOLD,
        S_ARMED
    } state_t;

    // With no hold configured the controller never leaves ARMED.
    localparam state_t POST_SWITCH_STATE = (MIN_HOLD_FRAMES == 0) ? S_ARMED : S_HOLD;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]        face_select_q, face_select_d;
    logic [1:0]        pend_face_q, pend_face_d;
    logic              pending_q, pending_d;
    logic              switch_pulse_q, switch_pulse_d;
    logic              req_error_q, req_error_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic       eof;
    logic       legal_req;
    logic       eff_pending;
    logic [1:0] eff_face;

`ifdef VGA_FACE_AUTOCYCLE_EN
    localparam int IDLE_W = (AUTO_IDLE_FRAMES > 0) ? $clog2(AUTO_IDLE_FRAMES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_IDLE_FRAMES - 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        eof       = st_valid & st_ready & st_endofpacket;
        legal_req = req_valid & (req_face != 2'd3);

        // A request in the same cycle as eof is folded in before the commit decision.
        eff_pending = pending_q;
        eff_face    = pend_face_q;
        if (legal_req) begin
            if (req_face == face_select_q) begin
                eff_pending = 1'b0;
            end else begin
                eff_pending = 1'b1;
                eff_face    = req_face;
            end
        end

        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        face_select_d  = face_select_q;
        pend_face_d    = eff_face;
        pending_d      = eff_pending;
        switch_pulse_d = 1'b0;
        req_error_d    = req_valid & (req_face == 2'd3);
        frame_count_d  = eof ? frame_count_q + 16'd1 : frame_count_q;

`ifdef VGA_FACE_AUTOCYCLE_EN
        // Saturates so a long HOLD still advances on the first ARMED frame boundary.
        idle_cnt_d = idle_cnt_q;
        if (legal_req) begin
            idle_cnt_d = '0;
        end else if (eof && (idle_cnt_q != IDLE_LAST)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
`endif

        if (eof) begin
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_ARMED;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                S_ARMED: begin
                    if (eff_pending) begin
                        face_select_d  = eff_face;
                        pending_d      = 1'b0;
                        switch_pulse_d = 1'b1;
                        hold_cnt_d     = '0;
                        state_d        = POST_SWITCH_STATE;
                    end
`ifdef VGA_FACE_AUTOCYCLE_EN
                    else if (!legal_req && (idle_cnt_q == IDLE_LAST)) begin
                        face_select_d  = (face_select_q >= 2'd2) ? 2'd0 : face_select_q + 2'd1;
                        switch_pulse_d = 1'b1;
                        hold_cnt_d     = '0;
                        idle_cnt_d     = '0;
                        state_d        = POST_SWITCH_STATE;
                    end
`endif
                end
                default: state_d = POST_SWITCH_STATE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= POST_SWITCH_STATE;
            hold_cnt_q     <= '0;
            face_select_q  <= DEFAULT_FACE;
            pend_face_q    <= DEFAULT_FACE;
            pending_q      <= 1'b0;
            switch_pulse_q <= 1'b0;
            req_error_q    <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            face_select_q  <= face_select_d;
            pend_face_q    <= pend_face_d;
            pending_q      <= pending_d;
            switch_pulse_q <= switch_pulse_d;
            req_error_q    <= req_error_d;
            frame_count_q  <= frame_count_d;
        end
    end

`ifdef VGA_FACE_AUTOCYCLE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign face_select  = face_select_q;
    assign switch_pulse = switch_pulse_q;
    assign pending      = pending_q;
    assign req_error    = req_error_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_face_scheduler.sv
// Scoreboard bench for vga_face_scheduler: expected faces are queued when a commit is provoked and
// popped by a monitor on every switch_pulse; scenario tasks check pending/error/frame state inline.
module tb_vga_face_scheduler;

    localparam int         MIN_HOLD  = 2;
    localparam int         AUTO_IDLE = 4;
    localparam logic [1:0] DEF_FACE  = 2'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_face = 2'd0;
    logic        st_valid = 1'b0;
    logic        st_ready = 1'b0;
    logic        st_endofpacket = 1'b0;
    logic [1:0]  face_select;
    logic        switch_pulse;
    logic        pending;
    logic        req_error;
    logic [15:0] frame_count;

    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_frames = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_face;

    vga_face_scheduler #(
        .MIN_HOLD_FRAMES (MIN_HOLD),
        .AUTO_IDLE_FRAMES(AUTO_IDLE),
        .DEFAULT_FACE    (DEF_FACE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_face      (req_face),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_endofpacket(st_endofpacket),
        .face_select   (face_select),
        .switch_pulse  (switch_pulse),
        .pending       (pending),
        .req_error     (req_error),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    // Every switch_pulse must match the oldest scheduled face.
    always @(negedge clk) begin
        if (!reset && switch_pulse) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_switch: face_select=%0d, no switch scheduled", face_select);
            end else begin
                exp_face = exp_q.pop_front();
                if (face_select !== exp_face) begin
                    n_fail++;
                    $display("[TB] FAIL switch_face: got %0d, expected %0d", face_select, exp_face);
                end
            end
        end
    end

    task automatic cyc(input logic rv, input logic [1:0] rf, input logic sv, input logic sr, input logic se);
        req_valid      = rv;
        req_face       = rf;
        st_valid       = sv;
        st_ready       = sr;
        st_endofpacket = se;
        if (sv && sr && se) exp_frames = (exp_frames + 1) % 65536;
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
        req_face       = 2'd0;
        st_valid       = 1'b0;
        st_ready       = 1'b0;
        st_endofpacket = 1'b0;
    endtask

    task automatic idle();                    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0); endtask
    task automatic req(input logic [1:0] f);  cyc(1'b1, f,    1'b0, 1'b0, 1'b0); endtask
    task automatic eof();                     cyc(1'b0, 2'd0, 1'b1, 1'b1, 1'b1); endtask
    task automatic eof_req(input logic [1:0] f); cyc(1'b1, f, 1'b1, 1'b1, 1'b1); endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({face_select, switch_pulse, pending, req_error} !== {DEF_FACE, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: face=%0d sw=%0b pend=%0b err=%0b, expected face=%0d others 0",
                     face_select, switch_pulse, pending, req_error, DEF_FACE);
        end
        n_checks++;
        if (frame_count !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_frame_count: got %0d, expected 0", frame_count);
        end
        reset = 1'b0;
        exp_frames = 0;
    endtask

    task automatic test_hold_then_switch();
        req(2'd1);
        n_checks++;
        if (pending !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_pending: got %0b, expected 1", pending); end
        eof();
        n_checks++;
        if (face_select !== 2'd0) begin n_fail++; $display("[TB] FAIL hold_eof1_face: got %0d, expected 0", face_select); end
        eof();
        n_checks++;
        if (face_select !== 2'd0 || pending !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hold_eof2_arm: face=%0d pend=%0b, expected face=0 pend=1", face_select, pending);
        end
        exp_q.push_back(2'd1);
        eof();
        n_checks++;
        if (face_select !== 2'd1 || pending !== 1'b0 || switch_pulse !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hold_eof3_commit: face=%0d pend=%0b sw=%0b, expected 1/0/1", face_select, pending, switch_pulse);
        end
        n_checks++;
        if (frame_count !== 16'(exp_frames)) begin
            n_fail++;
            $display("[TB] FAIL hold_frame_count: got %0d, expected %0d", frame_count, exp_frames);
        end
        eof();
        eof();
        n_checks++;
        if (face_select !== 2'd1 || switch_pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rearm_no_switch: face=%0d sw=%0b, expected 1/0", face_select, switch_pulse);
        end
    endtask

    task automatic test_last_request_wins();
        req(2'd2);
        req(2'd1);
        n_checks++;
        if (pending !== 1'b0) begin n_fail++; $display("[TB] FAIL latest_equal_cancels: pend=%0b, expected 0", pending); end
        req(2'd2);
        exp_q.push_back(2'd2);
        eof();
        n_checks++;
        if (face_select !== 2'd2 || pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL latest_commit: face=%0d pend=%0b, expected 2/0", face_select, pending);
        end
        eof();
        eof();
    endtask

    task automatic test_cancel();
        req(2'd0);
        req(2'd2);
        n_checks++;
        if (pending !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_pending: got %0b, expected 0", pending); end
        eof();
        n_checks++;
        if (face_select !== 2'd2 || switch_pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cancel_no_switch: face=%0d sw=%0b, expected 2/0", face_select, switch_pulse);
        end
    endtask

    task automatic test_req_error();
        req(2'd1);
        req(2'd3);
        n_checks++;
        if (req_error !== 1'b1 || pending !== 1'b1 || face_select !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL error_pulse: err=%0b pend=%0b face=%0d, expected 1/1/2", req_error, pending, face_select);
        end
        idle();
        n_checks++;
        if (req_error !== 1'b0 || pending !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL error_one_cycle: err=%0b pend=%0b, expected 0/1", req_error, pending);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (face_select !== 2'd2 || frame_count !== 16'(exp_frames)) begin
                n_fail++;
                $display("[TB] FAIL stall_%0d: face=%0d frames=%0d, expected 2/%0d", i, face_select, frame_count, exp_frames);
            end
        end
        exp_q.push_back(2'd1);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (face_select !== 2'd1 || frame_count !== 16'(exp_frames)) begin
            n_fail++;
            $display("[TB] FAIL stall_release: face=%0d frames=%0d, expected 1/%0d", face_select, frame_count, exp_frames);
        end
    endtask

    task automatic test_same_cycle_merge();
        eof();
        eof();
        exp_q.push_back(2'd0);
        eof_req(2'd0);
        n_checks++;
        if (face_select !== 2'd0) begin n_fail++; $display("[TB] FAIL merge_commit: got %0d, expected 0", face_select); end
        eof();
        eof();
        req(2'd2);
        eof_req(2'd0);
        n_checks++;
        if (face_select !== 2'd0 || pending !== 1'b0 || switch_pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL merge_cancel: face=%0d pend=%0b sw=%0b, expected 0/0/0", face_select, pending, switch_pulse);
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_q.push_back(2'd2);
        eof_req(2'd2);
        eof();
        req(2'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_frames = 0;
        n_checks++;
        if (face_select !== DEF_FACE || frame_count !== 16'd0 || pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midhold_reset: face=%0d frames=%0d pend=%0b, expected 0/0/0", face_select, frame_count, pending);
        end
        req(2'd2);
        eof();
        eof();
        n_checks++;
        if (face_select !== 2'd0 || pending !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_hold: face=%0d pend=%0b, expected 0/1", face_select, pending);
        end
        exp_q.push_back(2'd2);
        eof();
        n_checks++;
        if (face_select !== 2'd2 || frame_count !== 16'(exp_frames)) begin
            n_fail++;
            $display("[TB] FAIL post_reset_commit: face=%0d frames=%0d, expected 2/%0d", face_select, frame_count, exp_frames);
        end
    endtask

`ifdef VGA_FACE_AUTOCYCLE_EN
    task automatic test_autocycle();
        eof();
        eof();
        req(2'd2);
        for (int i = 0; i < AUTO_IDLE - 1; i++) begin
            eof();
            n_checks++;
            if (face_select !== 2'd2) begin
                n_fail++;
                $display("[TB] FAIL auto_early_%0d: face=%0d, expected 2", i, face_select);
            end
        end
        exp_q.push_back(2'd0);
        eof();
        n_checks++;
        if (face_select !== 2'd0) begin n_fail++; $display("[TB] FAIL auto_advance: got %0d, expected 0", face_select); end
    endtask
`endif

    initial begin
        test_reset();
        test_hold_then_switch();
        test_last_request_wins();
        test_cancel();
        test_req_error();
        test_backpressure();
        test_same_cycle_merge();
        test_reset_mid_hold();
`ifdef VGA_FACE_AUTOCYCLE_EN
        test_autocycle();
`endif
        idle();
        idle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL missing_switch: %0d scheduled switches never seen, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
